// File: rtl/vend_credit_if.sv
// vend_credit_if: strobe inputs and registered status outputs of the credit controller
interface vend_credit_if #(
  parameter int CREDIT_W = 3
);
  logic                coin_valid;
  logic [1:0]          coin_val;
  logic                sel_valid;
  logic [1:0]          sel;
  logic                refund_req;
  logic [CREDIT_W-1:0] credit;
  logic                busy;
  logic                dispense;
  logic [1:0]          item;
  logic                change_pulse;
  logic                coin_reject;
  logic                short_flag;
  modport master (
    output coin_valid, coin_val, sel_valid, sel, refund_req,
    input  credit, busy, dispense, item, change_pulse, coin_reject, short_flag
  );
  modport slave (
    input  coin_valid, coin_val, sel_valid, sel, refund_req,
    output credit, busy, dispense, item, change_pulse, coin_reject, short_flag
  );
endinterface

// File: rtl/vend_credit_controller.sv
// vend_credit_controller: credit accumulation, purchase and timed change payout
module vend_credit_controller #(
  parameter int CREDIT_W   = 3,
  parameter int MAX_CREDIT = 7,
  parameter int PRICE0     = 3,
  parameter int PRICE1     = 4,
  parameter int PRICE2     = 5,
  parameter int PRICE3     = 6
) (
  input logic         clk,
  input logic         reset,
  vend_credit_if.slave bus
);
  typedef enum logic {IDLE, CHANGE} state_t;
  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                phase_q, phase_d;
  logic                dispense_q, dispense_d;
  logic [1:0]          item_q, item_d;
  logic                pulse_q, pulse_d;
  logic                reject_q, reject_d;
  logic                short_q, short_d;
  logic [CREDIT_W:0]   price, sum, rem;
  logic                idle, coin_nz, act_ref, act_sel, act_coin, can_buy, sum_ok;
  assign price    = bus.sel == 2'd0 ? (CREDIT_W+1)'(PRICE0) :
                    bus.sel == 2'd1 ? (CREDIT_W+1)'(PRICE1) :
                    bus.sel == 2'd2 ? (CREDIT_W+1)'(PRICE2) : (CREDIT_W+1)'(PRICE3);
  // sum is one bit wider so an overflowing coin is rejected instead of wrapping
  assign sum      = {1'b0, credit_q} + (CREDIT_W+1)'(bus.coin_val);
  assign rem      = {1'b0, credit_q} - price;
  assign can_buy  = {1'b0, credit_q} >= price;
  assign sum_ok   = sum <= (CREDIT_W+1)'(MAX_CREDIT);
  assign idle     = state_q == IDLE;
  assign coin_nz  = bus.coin_valid && bus.coin_val != 2'd0;
  assign act_ref  = idle && bus.refund_req;
  assign act_sel  = idle && !bus.refund_req && bus.sel_valid;
  assign act_coin = idle && !bus.refund_req && !bus.sel_valid && coin_nz;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      phase_q    <= 1'b0;
      dispense_q <= 1'b0;
      item_q     <= 2'd0;
      pulse_q    <= 1'b0;
      reject_q   <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      phase_q    <= phase_d;
      dispense_q <= dispense_d;
      item_q     <= item_d;
      pulse_q    <= pulse_d;
      reject_q   <= reject_d;
      short_q    <= short_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    phase_d  = phase_q;
    if (idle) begin
      if (act_ref && credit_q != '0) begin
        state_d = CHANGE;
        phase_d = 1'b0;
      end
      if (act_sel && can_buy) begin
        credit_d = rem[CREDIT_W-1:0];
        phase_d  = 1'b0;
        state_d  = rem != '0 ? CHANGE : IDLE;
      end
      if (act_coin && sum_ok) credit_d = sum[CREDIT_W-1:0];
    end else if (!phase_q) begin
      credit_d = credit_q - CREDIT_W'(1);
      phase_d  = 1'b1;
    end else begin
      phase_d = 1'b0;
      state_d = credit_q == '0 ? IDLE : CHANGE;
    end
  end
  always_comb begin
    dispense_d = act_sel && can_buy;
    item_d     = dispense_d ? bus.sel : 2'd0;
    short_d    = act_sel && !can_buy;
    pulse_d    = !idle && !phase_q;
    reject_d   = coin_nz && (!idle || bus.refund_req || bus.sel_valid || !sum_ok);
  end
  assign bus.credit       = credit_q;
  assign bus.busy         = state_q == CHANGE;
  assign bus.dispense     = dispense_q;
  assign bus.item         = item_q;
  assign bus.change_pulse = pulse_q;
  assign bus.coin_reject  = reject_q;
  assign bus.short_flag   = short_q;
endmodule

// File: tb/tb_vend_credit_controller.sv
// tb_vend_credit_controller: directed vectors with hand-computed expectations
module tb_vend_credit_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;
  int   pulses;
  vend_credit_if #(.CREDIT_W(3)) bus ();
  vend_credit_controller dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.coin_valid = 0; bus.coin_val = 0; bus.sel_valid = 0; bus.sel = 0; bus.refund_req = 0;
  endtask

  task automatic coin(input logic [1:0] v);
    bus.coin_valid = 1; bus.coin_val = v;
    tick();
    idle_in();
  endtask

  task automatic pick(input logic [1:0] s);
    bus.sel_valid = 1; bus.sel = s;
    tick();
    idle_in();
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  initial begin
    idle_in();
    do_reset();
    check("rst_credit", bus.credit, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_outs", {bus.dispense, bus.item, bus.change_pulse, bus.coin_reject, bus.short_flag}, 0);
    // 1: coin accumulation
    coin(2); check("t1_credit2", bus.credit, 2); check("t1_rej", bus.coin_reject, 0);
    coin(2); check("t1_credit4", bus.credit, 4);
    coin(0); check("t1_zero_coin", bus.credit, 4); check("t1_zero_rej", bus.coin_reject, 0);
    coin(1); check("t1_credit5", bus.credit, 5); check("t1_busy", bus.busy, 0);
    // 2: exact purchase
    pick(2);
    check("t2_disp", bus.dispense, 1); check("t2_item", bus.item, 2);
    check("t2_credit", bus.credit, 0); check("t2_busy", bus.busy, 0);
    check("t2_pulse", bus.change_pulse, 0);
    tick(); check("t2_disp_once", bus.dispense, 0);
    // 3: purchase with change
    coin(3); coin(3); coin(1); check("t3_credit7", bus.credit, 7);
    pick(0);
    check("t3_disp", bus.dispense, 1); check("t3_item", bus.item, 0);
    check("t3_credit", bus.credit, 4); check("t3_busy", bus.busy, 1);
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      pulses += bus.change_pulse;
      check($sformatf("t3_pulse%0d", i), bus.change_pulse, i % 2);
      check($sformatf("t3_cr%0d", i), bus.credit, 4 - (i + 1) / 2);
      if (i == 7) check("t3_busy7", bus.busy, 1);
    end
    check("t3_npulse", pulses, 4);
    check("t3_busy_end", bus.busy, 0);
    // 4: saturation, then short
    coin(3); coin(3); check("t4_credit6", bus.credit, 6);
    coin(2); check("t4_rej", bus.coin_reject, 1); check("t4_credit", bus.credit, 6);
    tick(); check("t4_rej_once", bus.coin_reject, 0);
    do_reset();
    coin(3); coin(2); check("t4_credit5", bus.credit, 5);
    pick(3);
    check("t4_short", bus.short_flag, 1); check("t4_short_cr", bus.credit, 5);
    check("t4_short_disp", bus.dispense, 0);
    tick(); check("t4_short_once", bus.short_flag, 0);
    // 5: priority, then coin during CHANGE
    do_reset();
    coin(3);
    bus.refund_req = 1; bus.sel_valid = 1; bus.sel = 0; bus.coin_valid = 1; bus.coin_val = 1;
    tick();
    idle_in();
    check("t5_rej", bus.coin_reject, 1); check("t5_disp", bus.dispense, 0);
    check("t5_busy", bus.busy, 1); check("t5_credit", bus.credit, 3);
    pulses = 0;
    for (int i = 1; i <= 6; i++) begin
      if (i == 2) begin bus.coin_valid = 1; bus.coin_val = 1; end
      tick();
      idle_in();
      pulses += bus.change_pulse;
      if (i == 2) check("t5_busy_rej", bus.coin_reject, 1);
    end
    check("t5_npulse", pulses, 3);
    check("t5_busy_end", bus.busy, 0); check("t5_credit_end", bus.credit, 0);
    // 6: reset during CHANGE
    coin(3); coin(3); coin(1);
    bus.refund_req = 1;
    tick();
    idle_in();
    check("t6_busy", bus.busy, 1);
    tick(); tick(); tick();
    check("t6_pulse2", bus.change_pulse, 1); check("t6_credit5", bus.credit, 5);
    reset = 1;
    tick();
    reset = 0;
    check("t6_credit", bus.credit, 0); check("t6_busy_rst", bus.busy, 0);
    check("t6_pulse_rst", bus.change_pulse, 0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pulses += bus.change_pulse;
    end
    check("t6_no_pulses", pulses, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/vend_credit_controller.md
Name: vend_credit_controller

Overview:
Sequential stage directly downstream of the vending machine's combinational next-state logic. It holds the registered credit state and runs the purchase and change sequence.
- Accepts coin pulses and item selections.
- Accumulates credit with saturation checking.
- Issues a one-cycle dispense strobe and pays change out as timed unit pulses.
- Drives the machine's credit display and busy indication.

Parameters:
CREDIT_W, 3, width of credit register (credit in coin units)
MAX_CREDIT, 7, highest credit value accepted; must be <= 2^CREDIT_W-1
PRICE0, 3, price of item 0 in units
PRICE1, 4, price of item 1 in units
PRICE2, 5, price of item 2 in units
PRICE3, 6, price of item 3 in units

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
coin_valid  input  1  one-cycle coin strobe
coin_val  input  2  coin value in units (1..3); 0 = no-op
sel_valid  input  1  one-cycle item-select strobe
sel  input  2  item index 0..3
refund_req  input  1  one-cycle request to return all credit
credit  output  CREDIT_W  current credit
busy  output  1  high while not in IDLE
dispense  output  1  one-cycle dispense strobe
item  output  2  item being dispensed; valid with dispense
change_pulse  output  1  one unit of change returned per high cycle
coin_reject  output  1  one-cycle: coin not accepted
short_flag  output  1  one-cycle: selection refused, credit < price

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset; it takes priority over all inputs.
- Reset values: state = IDLE, credit = 0, phase = 0, and all outputs 0. This includes busy, dispense, item, change_pulse, coin_reject and short_flag.
- Reset mid-CHANGE: credit in progress is discarded.
- Registered outputs: every output is registered. Strobes sampled at edge N produce a response visible from edge N for one cycle.
- States: IDLE and CHANGE. busy = (state == CHANGE).
- IDLE input priority: refund_req > sel_valid > coin_valid. Only the highest-priority valid input acts.
- Lower-priority coin that loses arbitration: if coin_val != 0, the coin is rejected (coin_reject = 1, credit unchanged). A losing sel is silently ignored.
- Refund in IDLE:
  - credit > 0: go to CHANGE with phase = 0.
  - credit == 0: no-op.
- Select in IDLE, credit >= PRICE[sel]:
  - dispense = 1, item = sel, credit <= credit - PRICE[sel].
  - Remainder > 0: go to CHANGE (phase = 0). Remainder == 0: stay IDLE.
- Select in IDLE, credit < PRICE[sel]: short_flag = 1; credit and state unchanged.
- Coin in IDLE:
  - coin_val == 0: ignored.
  - credit + coin_val <= MAX_CREDIT: credit += coin_val. Compute the sum one bit wider than CREDIT_W; no wrap.
  - Sum > MAX_CREDIT: coin_reject = 1, credit unchanged.
- CHANGE, phase 0: change_pulse = 1, credit -= 1, phase = 1.
- CHANGE, phase 1: change_pulse = 0, phase = 0. If credit == 0, go to IDLE.
- CHANGE timing: pulses are spaced 2 cycles apart. A remainder R gives R pulses, and busy falls 2R cycles after entry.
- Inputs during CHANGE:
  - coin_valid with coin_val != 0: coin_reject = 1.
  - sel_valid and refund_req: ignored.
  - credit is never incremented in CHANGE.
- Strobe defaults: dispense, coin_reject and short_flag default to 0 each cycle. They are never high for two consecutive cycles from a single strobe.
- Credit bounds: credit never exceeds MAX_CREDIT and never underflows below 0.

Test Plan:
1. Reset then coins: reset 2 cycles, then coins 2, 2, 1 on separate cycles -> credit 2, 4, 5; busy = 0; no rejects.
2. Exact purchase: credit 5, sel = 2 -> next cycle dispense = 1, item = 2, credit = 0; busy stays 0; no change_pulse.
3. Purchase with change: credit 7, sel = 0 -> dispense = 1, item = 0, credit = 4, busy = 1. Then exactly 4 change_pulse cycles on alternate cycles, credit 3, 2, 1, 0, and busy = 0 eight cycles after dispense.
4. Saturation and short: credit 6, coin 2 -> coin_reject = 1, credit stays 6. Then sel = 3 with credit 5 -> short_flag = 1, credit stays 5, no dispense.
5. Priority and busy:
   - Same cycle refund_req, sel_valid and coin 1 at credit 3 -> coin_reject = 1, no dispense, CHANGE entered, 3 change pulses.
   - Coin 1 during CHANGE -> coin_reject = 1, pulse count unaffected.
6. Reset mid-CHANGE: credit 7, refund, assert reset after the 2nd change_pulse -> next cycle credit = 0, busy = 0, change_pulse = 0; no further pulses.
